mem_arbiter: RTL

Arbitrates the single shared memory bus port between instruction fetch (IFU) and load/store (LSU) and sequences each transaction through request, grant and response. One transaction is outstanding at a time. Per-requester stall requests go to the pipeline controller. A flush input aborts or discards in-flight instruction fetches.

---
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one memory bus port between instruction fetch (IFU)
//                and load/store (LSU). One transaction is outstanding at a
//                time and is sequenced IDLE -> REQ -> WAIT. Ties between the
//                two requesters alternate (round-robin). A pipeline flush
//                aborts or silently discards an IFU transaction, and a
//                timeout abandons a transaction the bus never completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_gnt_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_err_o,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,

    input  logic        flush_i,
    output logic        ifu_stallreq_o,
    output logic        lsu_stallreq_o
);

    // Counter is at least 8 bits and wide enough to hold TIMEOUT.
    localparam int c_CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // Counter value during the last permitted cycle of REQ or WAIT.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic c_OWN_IFU = 1'b0;
    localparam logic c_OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_owner;
    logic                 r_last_owner;
    logic                 r_drop;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_bus_req;
    logic                 r_bus_we;
    logic [3:0]           r_bus_be;
    logic [31:0]          r_bus_addr;
    logic [31:0]          r_bus_wdata;

    logic w_in_req;
    logic w_in_wait;
    logic w_own_ifu;
    logic w_ifu_flush;
    logic w_last;
    logic w_gnt_evt;
    logic w_rsp_evt;
    logic w_tmo;
    logic w_suppress;
    logic w_ifu_cand;
    logic w_pick_lsu;
    logic w_pick_ifu;
    logic w_ifu_busy;
    logic w_lsu_busy;

    assign w_in_req    = (r_state == S_REQ);
    assign w_in_wait   = (r_state == S_WAIT);
    assign w_own_ifu   = (r_owner == c_OWN_IFU);
    // A flush only concerns the transaction when IFU owns it.
    assign w_ifu_flush = flush_i & w_own_ifu;
    assign w_last      = (r_cnt == c_CNT_LAST);

    // Handshake events; gated with reset so reset overrides mid-transaction.
    assign w_gnt_evt = rst_n & w_in_req & bus_gnt_i;
    assign w_rsp_evt = rst_n & w_in_wait & bus_rvalid_i;
    // Timeout fires in the last allowed cycle unless that cycle completes the
    // phase; an unaccepted IFU request being flushed is an abort, not a timeout.
    assign w_tmo = rst_n & w_last &
                   ((w_in_req & ~bus_gnt_i & ~w_ifu_flush) |
                    (w_in_wait & ~bus_rvalid_i));
    // IFU-visible completion is hidden once the fetch has been flushed.
    assign w_suppress = r_drop | w_ifu_flush;

    assign ifu_gnt_o    = w_gnt_evt & w_own_ifu;
    assign lsu_gnt_o    = w_gnt_evt & ~w_own_ifu;
    assign ifu_rvalid_o = w_rsp_evt & w_own_ifu & ~w_suppress;
    assign lsu_rvalid_o = w_rsp_evt & ~w_own_ifu;
    assign ifu_err_o    = w_tmo & w_own_ifu & ~w_suppress;
    assign lsu_err_o    = w_tmo & ~w_own_ifu;

    assign ifu_rdata_o = bus_rdata_i;
    assign lsu_rdata_o = bus_rdata_i;

    // Round-robin: on a tie, the requester that did not finish last wins.
    // A flushed IFU request is not a candidate in that cycle.
    assign w_ifu_cand = ifu_req_i & ~flush_i;
    assign w_pick_lsu = lsu_req_i & (~w_ifu_cand | (r_last_owner == c_OWN_IFU));
    assign w_pick_ifu = w_ifu_cand & ~w_pick_lsu;

    // A requester stalls while it asks or while its transaction is in flight,
    // and releases in the cycle its response or error arrives.
    assign w_ifu_busy = rst_n & (r_state != S_IDLE) & w_own_ifu & ~r_drop;
    assign w_lsu_busy = rst_n & (r_state != S_IDLE) & ~w_own_ifu;
    assign ifu_stallreq_o = (ifu_req_i | w_ifu_busy) & ~ifu_rvalid_o & ~ifu_err_o;
    assign lsu_stallreq_o = (lsu_req_i | w_lsu_busy) & ~lsu_rvalid_o & ~lsu_err_o;

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_be_o    = r_bus_be;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;

    // Transaction sequencer with registered bus payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= c_OWN_IFU;
            r_last_owner <= c_OWN_IFU;
            r_drop       <= 1'b0;
            r_cnt        <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_be     <= 4'h0;
            r_bus_addr   <= 32'h0;
            r_bus_wdata  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_drop <= 1'b0;
                    r_cnt  <= '0;
                    if (w_pick_lsu) begin
                        r_state     <= S_REQ;
                        r_owner     <= c_OWN_LSU;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= lsu_we_i;
                        r_bus_be    <= lsu_be_i;
                        r_bus_addr  <= lsu_addr_i;
                        r_bus_wdata <= lsu_wdata_i;
                    end else if (w_pick_ifu) begin
                        r_state     <= S_REQ;
                        r_owner     <= c_OWN_IFU;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_be    <= 4'hF;
                        r_bus_addr  <= ifu_addr_i;
                        r_bus_wdata <= 32'h0;
                    end
                end

                S_REQ: begin
                    if (bus_gnt_i) begin
                        // Accepted: a simultaneous flush still lets the
                        // response drain, but it will be discarded.
                        r_state   <= S_WAIT;
                        r_bus_req <= 1'b0;
                        r_cnt     <= '0;
                        if (w_ifu_flush) begin
                            r_drop <= 1'b1;
                        end
                    end else if (w_ifu_flush || w_last) begin
                        r_state   <= S_IDLE;
                        r_bus_req <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_WAIT: begin
                    if (bus_rvalid_i) begin
                        r_state      <= S_IDLE;
                        r_last_owner <= r_owner;
                        r_drop       <= 1'b0;
                    end else if (w_last) begin
                        r_state <= S_IDLE;
                        r_drop  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (w_ifu_flush) begin
                            r_drop <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
